// File: rtl/atom_kbd_pkg.sv
// Shared types for the Atom PS/2 keyboard: decoder states, key targets and the set-2 scancode table.
// Pure declarations; no timing and no flow control.
package atom_kbd_pkg;

   localparam logic [7:0] PS2_BRK = 8'hF0;
   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam int         ROWS    = 10;
   localparam int         COLS    = 6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BRK,
      ST_EXT,
      ST_EXT_BRK
   } dec_state_e;

   typedef enum logic [2:0] {
      KT_NONE,
      KT_MATRIX,
      KT_LSHIFT,
      KT_RSHIFT,
      KT_LCTRL,
      KT_RCTRL,
      KT_REPT,
      KT_BREAK
   } key_kind_e;

   typedef struct packed {
      key_kind_e   kind;
      logic [3:0]  row;
      logic [2:0]  col;
   } key_tgt_t;

   function automatic key_tgt_t km(input int r, input int c);
      key_tgt_t t;
      t.kind = KT_MATRIX;
      t.row  = 4'(r);
      t.col  = 3'(c);
      return t;
   endfunction

   function automatic key_tgt_t kmod(input key_kind_e k);
      key_tgt_t t;
      t.kind = k;
      t.row  = 4'd0;
      t.col  = 3'd0;
      return t;
   endfunction

   // Key is {ext, code}; anything not listed (BAT, ACK, unused keys) maps to KT_NONE.
   function automatic key_tgt_t ps2_lookup(input logic [8:0] key);
      key_tgt_t t;
      t = kmod(KT_NONE);
      case (key)
         9'h076: t = km(0, 0);   9'h015: t = km(0, 1);   9'h034: t = km(0, 2);
         9'h04E: t = km(0, 3);   9'h026: t = km(0, 4);   9'h01A: t = km(0, 5);
         9'h00D: t = km(1, 0);   9'h04D: t = km(1, 1);   9'h02B: t = km(1, 2);
         9'h041: t = km(1, 3);   9'h01E: t = km(1, 4);   9'h035: t = km(1, 5);
         9'h175: t = km(2, 0);   9'h044: t = km(2, 1);   9'h024: t = km(2, 2);
         9'h04C: t = km(2, 3);   9'h016: t = km(2, 4);   9'h022: t = km(2, 5);
         9'h174: t = km(3, 0);   9'h031: t = km(3, 1);   9'h023: t = km(3, 2);
         9'h052: t = km(3, 3);   9'h045: t = km(3, 4);   9'h01C: t = km(3, 5);
         9'h058: t = km(4, 0);   9'h03A: t = km(4, 1);   9'h021: t = km(4, 2);
         9'h046: t = km(4, 3);   9'h04A: t = km(4, 4);   9'h01D: t = km(4, 5);
         9'h16B: t = km(5, 0);   9'h04B: t = km(5, 1);   9'h032: t = km(5, 2);
         9'h03E: t = km(5, 3);   9'h049: t = km(5, 4);   9'h02A: t = km(5, 5);
         9'h172: t = km(6, 0);   9'h042: t = km(6, 1);   9'h05B: t = km(6, 2);
         9'h03D: t = km(6, 3);   9'h055: t = km(6, 4);   9'h03C: t = km(6, 5);
         9'h05A: t = km(7, 0);   9'h03B: t = km(7, 1);   9'h05D: t = km(7, 2);
         9'h036: t = km(7, 3);   9'h00E: t = km(7, 4);   9'h02C: t = km(7, 5);
         9'h066: t = km(8, 0);   9'h043: t = km(8, 1);   9'h054: t = km(8, 2);
         9'h02E: t = km(8, 3);   9'h033: t = km(8, 4);   9'h01B: t = km(8, 5);
         9'h029: t = km(9, 0);   9'h02D: t = km(9, 1);   9'h171: t = km(9, 2);
         9'h025: t = km(9, 3);   9'h169: t = km(9, 4);   9'h15A: t = km(7, 0);
         9'h012: t = kmod(KT_LSHIFT);
         9'h059: t = kmod(KT_RSHIFT);
         9'h014: t = kmod(KT_LCTRL);
         9'h114: t = kmod(KT_RCTRL);
         9'h011: t = kmod(KT_REPT);
         9'h111: t = kmod(KT_REPT);
         9'h009: t = kmod(KT_BREAK);
         default: t = kmod(KT_NONE);
      endcase
      return t;
   endfunction

endpackage

// File: rtl/atom_ps2_keyboard_ps2_rx.sv
// PS/2 byte receiver: 2-FF sync, falling-edge sampling, odd parity and stop check, idle timeout.
// byte_valid_o pulses 3 clk after the stop-bit edge reaches the pin; no backpressure, one byte per frame.
module ps2_rx #(
   parameter int TIMEOUT = 25000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic [7:0] byte_o,
   output logic       byte_valid_o
);

   localparam int TW = $clog2(TIMEOUT + 1);

   // [0],[1] synchroniser stages, [2] previous synchronised value for edge detect
   logic [2:0]    clk_sync_q;
   logic [1:0]    data_sync_q;
   logic [3:0]    cnt_q, cnt_d;
   logic [7:0]    sr_q, sr_d;
   logic          par_q, par_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [7:0]    byte_q, byte_d;
   logic          byte_valid_q, byte_valid_d;
   logic          fall;
   logic          din;

   assign fall = clk_sync_q[2] & ~clk_sync_q[1];
   assign din  = data_sync_q[1];

   always_comb begin
      cnt_d        = cnt_q;
      sr_d         = sr_q;
      par_d        = par_q;
      byte_d       = byte_q;
      byte_valid_d = 1'b0;
      timer_d      = (cnt_q != 4'd0) ? timer_q + TW'(1) : '0;
      if (fall) begin
         timer_d = '0;
         if (cnt_q == 4'd0) begin
            if (!din) cnt_d = 4'd1;
         end else if (cnt_q <= 4'd8) begin
            sr_d  = {din, sr_q[7:1]};
            cnt_d = cnt_q + 4'd1;
         end else if (cnt_q == 4'd9) begin
            par_d = din;
            cnt_d = cnt_q + 4'd1;
         end else begin
            cnt_d = 4'd0;
            if (din && (^{sr_q, par_q})) begin
               byte_d       = sr_q;
               byte_valid_d = 1'b1;
            end
         end
      end else if ((cnt_q != 4'd0) && (timer_q == TW'(TIMEOUT - 1))) begin
         cnt_d   = 4'd0;
         timer_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_sync_q   <= 3'b111;
         data_sync_q  <= 2'b11;
         cnt_q        <= 4'd0;
         sr_q         <= 8'h00;
         par_q        <= 1'b0;
         timer_q      <= '0;
         byte_q       <= 8'h00;
         byte_valid_q <= 1'b0;
      end else begin
         clk_sync_q   <= {clk_sync_q[1:0], ps2_clk_i};
         data_sync_q  <= {data_sync_q[0], ps2_data_i};
         cnt_q        <= cnt_d;
         sr_q         <= sr_d;
         par_q        <= par_d;
         timer_q      <= timer_d;
         byte_q       <= byte_d;
         byte_valid_q <= byte_valid_d;
      end
   end

   assign byte_o       = byte_q;
   assign byte_valid_o = byte_valid_q;

endmodule

// File: rtl/atom_ps2_keyboard.sv
// Atom keyboard front end: decodes PS/2 make/break sequences into a 10x6 matrix and modifier lines.
// Matrix/strobe update 4 clk after the stop-bit edge, row->keyout is combinational; no backpressure.
module atom_ps2_keyboard
   import atom_kbd_pkg::*;
#(
   parameter int TIMEOUT = 25000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic [3:0] row,
   output logic [5:0] keyout,
   output logic       shift_n,
   output logic       ctrl_n,
   output logic       rept_n,
   output logic       break_n,
   output logic       key_strobe
);

   logic [7:0]          rx_byte;
   logic                rx_vld;
   dec_state_e          state_q, state_d;
   logic [9:0][5:0]     matrix_q, matrix_d;
   logic [1:0]          shift_q, shift_d;
   logic [1:0]          ctrl_q, ctrl_d;
   logic                rept_q, rept_d;
   logic                brk_q, brk_d;
   logic                strobe_q, strobe_d;
   logic                apply;
   logic                is_brk;
   logic                is_ext;
   key_tgt_t            tgt;

   ps2_rx #(.TIMEOUT(TIMEOUT)) u_rx (
      .clk          (clk),
      .reset_n      (reset_n),
      .ps2_clk_i    (ps2_clk),
      .ps2_data_i   (ps2_data),
      .byte_o       (rx_byte),
      .byte_valid_o (rx_vld)
   );

   // Prefix bytes seen in a break state restart the sequence; E0 inside EXT is just an unmapped key.
   always_comb begin
      state_d = state_q;
      apply   = 1'b0;
      is_brk  = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
      is_ext  = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
      if (rx_vld) begin
         if (rx_byte == PS2_BRK) begin
            state_d = (state_q == ST_EXT) ? ST_EXT_BRK : ST_BRK;
         end else if ((rx_byte == PS2_EXT) && (state_q != ST_EXT)) begin
            state_d = ST_EXT;
         end else begin
            apply   = 1'b1;
            state_d = ST_IDLE;
         end
      end
   end

   assign tgt = ps2_lookup({is_ext, rx_byte});

   always_comb begin
      matrix_d = matrix_q;
      shift_d  = shift_q;
      ctrl_d   = ctrl_q;
      rept_d   = rept_q;
      brk_d    = brk_q;
      strobe_d = 1'b0;
      if (apply) begin
         strobe_d = (tgt.kind != KT_NONE);
         case (tgt.kind)
            KT_MATRIX: matrix_d[tgt.row][tgt.col] = is_brk;
            KT_LSHIFT: shift_d[0] = is_brk;
            KT_RSHIFT: shift_d[1] = is_brk;
            KT_LCTRL:  ctrl_d[0]  = is_brk;
            KT_RCTRL:  ctrl_d[1]  = is_brk;
            KT_REPT:   rept_d     = is_brk;
            KT_BREAK:  brk_d      = is_brk;
            default:   strobe_d   = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         matrix_q <= '1;
         shift_q  <= 2'b11;
         ctrl_q   <= 2'b11;
         rept_q   <= 1'b1;
         brk_q    <= 1'b1;
         strobe_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         matrix_q <= matrix_d;
         shift_q  <= shift_d;
         ctrl_q   <= ctrl_d;
         rept_q   <= rept_d;
         brk_q    <= brk_d;
         strobe_q <= strobe_d;
      end
   end

   assign keyout     = (row <= 4'd9) ? matrix_q[row] : 6'b111111;
   assign shift_n    = &shift_q;
   assign ctrl_n     = &ctrl_q;
   assign rept_n     = rept_q;
   assign break_n    = brk_q;
   assign key_strobe = strobe_q;

endmodule

// File: tb/tb_atom_ps2_keyboard.sv
// Directed bench for atom_ps2_keyboard: PS/2 frames driven bit by bit, outputs checked against hand values.
module tb_atom_ps2_keyboard;

   localparam int TO = 200;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [3:0] row = 4'd3;
   logic [5:0] keyout;
   logic       shift_n, ctrl_n, rept_n, break_n, key_strobe;

   int n_total = 0;
   int n_pass  = 0;
   int strobes = 0;
   int s0;

   atom_ps2_keyboard #(.TIMEOUT(TO)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .row        (row),
      .keyout     (keyout),
      .shift_n    (shift_n),
      .ctrl_n     (ctrl_n),
      .rept_n     (rept_n),
      .break_n    (break_n),
      .key_strobe (key_strobe)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (key_strobe === 1'b1) strobes++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [10:0] frame(input logic [7:0] b, input logic bad_par, input logic stop);
      return {stop, (~^b) ^ bad_par, b, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = bits[i];
         cyc(5);
         ps2_clk = 1'b0;
         cyc(10);
         ps2_clk = 1'b1;
         cyc(5);
      end
      ps2_data = 1'b1;
   endtask

   task automatic send(input logic [7:0] b);
      send_bits(frame(b, 1'b0, 1'b1), 11);
      cyc(5);
   endtask

   initial begin
      cyc(4);
      chk("reset_keyout", 32'(keyout), 32'h3F);
      chk("reset_shift", 32'(shift_n), 32'h1);
      chk("reset_ctrl", 32'(ctrl_n), 32'h1);
      chk("reset_rept", 32'(rept_n), 32'h1);
      chk("reset_break", 32'(break_n), 32'h1);
      chk("reset_strobe", 32'(key_strobe), 32'h0);
      reset_n = 1'b1;
      cyc(5);

      // A make with exact latency from the stop-bit edge
      s0 = strobes;
      send_bits(frame(8'h1C, 1'b0, 1'b1), 10);
      ps2_data = 1'b1;
      cyc(5);
      ps2_clk = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("lat_strobe_early", 32'(key_strobe), 32'h0);
      chk("lat_keyout_early", 32'(keyout), 32'h3F);
      @(posedge clk);
      #1 chk("lat_strobe_hit", 32'(key_strobe), 32'h1);
      chk("a_make_keyout", 32'(keyout), 32'h1F);
      @(posedge clk);
      #1 chk("lat_strobe_once", 32'(key_strobe), 32'h0);
      cyc(8);
      ps2_clk = 1'b1;
      cyc(5);
      chk("a_make_strobes", 32'(strobes - s0), 32'd1);
      send(8'hF0); send(8'h1C);
      chk("a_break_keyout", 32'(keyout), 32'h3F);

      send(8'h29);
      row = 4'd9; #1;
      chk("space_row9", 32'(keyout), 32'h3E);
      for (int r = 10; r < 16; r++) begin
         row = 4'(r); #1;
         chk("row_out_of_range", 32'(keyout), 32'h3F);
      end
      send(8'hF0); send(8'h29);
      row = 4'd9; #1;
      chk("space_release", 32'(keyout), 32'h3F);

      send(8'h12);               chk("lshift_make", 32'(shift_n), 32'h0);
      send(8'h59);               chk("rshift_make", 32'(shift_n), 32'h0);
      send(8'hF0); send(8'h12);  chk("lshift_break", 32'(shift_n), 32'h0);
      send(8'hF0); send(8'h59);  chk("rshift_break", 32'(shift_n), 32'h1);
      send(8'hE0); send(8'h14);  chk("rctrl_make", 32'(ctrl_n), 32'h0);
      send(8'h14);               chk("lctrl_make", 32'(ctrl_n), 32'h0);
      send(8'hE0); send(8'hF0); send(8'h14);
      chk("rctrl_break", 32'(ctrl_n), 32'h0);
      send(8'hF0); send(8'h14);  chk("lctrl_break", 32'(ctrl_n), 32'h1);
      chk("ctrl_shift_indep", 32'(shift_n), 32'h1);

      row = 4'd3;
      s0 = strobes;
      send_bits(frame(8'h1C, 1'b1, 1'b1), 11);
      cyc(10);
      chk("bad_parity_strobe", 32'(strobes - s0), 32'd0);
      chk("bad_parity_keyout", 32'(keyout), 32'h3F);
      send_bits(frame(8'h1C, 1'b0, 1'b0), 11);
      cyc(10);
      chk("bad_stop_strobe", 32'(strobes - s0), 32'd0);
      chk("bad_stop_keyout", 32'(keyout), 32'h3F);
      send_bits(frame(8'h1C, 1'b0, 1'b1), 5);
      cyc(TO + 10);
      send(8'h1C);
      chk("timeout_recover", 32'(keyout), 32'h1F);
      send(8'hF0); send(8'h1C);
      chk("timeout_release", 32'(keyout), 32'h3F);

      send(8'h09);               chk("f10_make", 32'(break_n), 32'h0);
      s0 = strobes;
      send(8'hAA); send(8'hFA);
      chk("bat_ack_strobe", 32'(strobes - s0), 32'd0);
      chk("bat_ack_break", 32'(break_n), 32'h0);
      chk("bat_ack_keyout", 32'(keyout), 32'h3F);
      send(8'hF0); send(8'h09);  chk("f10_break", 32'(break_n), 32'h1);
      send(8'h11);               chk("alt_make", 32'(rept_n), 32'h0);
      send(8'hF0); send(8'h11);  chk("alt_break", 32'(rept_n), 32'h1);

      send(8'h1C);
      send(8'h12);
      chk("pre_reset_keyout", 32'(keyout), 32'h1F);
      send_bits(frame(8'h29, 1'b0, 1'b1), 6);
      reset_n = 1'b0;
      #1;
      chk("midreset_keyout", 32'(keyout), 32'h3F);
      chk("midreset_shift", 32'(shift_n), 32'h1);
      chk("midreset_strobe", 32'(key_strobe), 32'h0);
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      cyc(5);
      reset_n = 1'b1;
      cyc(5);
      send(8'h29);
      row = 4'd9; #1;
      chk("post_reset_space", 32'(keyout), 32'h3E);
      row = 4'd3; #1;
      chk("post_reset_a", 32'(keyout), 32'h3F);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
